// File: rtl/mem_access_ctrl.sv
// MEM stage controller: splits 32-bit loads/stores into two 16-bit SRAM accesses
// and stalls the pipeline until they are done, then updates the MEM/WB register.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] MEM_BASE    = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_ENIn,
    input  logic        MEM_R_ENIn,
    input  logic        MEM_W_ENIn,
    input  logic [31:0] ALUResIn,
    input  logic [31:0] RMValIn,
    input  logic [3:0]  DestIn,
    output logic        Freeze,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_WDATA,
    input  logic [15:0] SRAM_RDATA,
    output logic        SRAM_WE_N,
    output logic        WB_ENOut,
    output logic        MEM_R_ENOut,
    output logic [31:0] ALUResOut,
    output logic [31:0] MemDataOut,
    output logic [3:0]  DestOut
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;

    logic        mem_req, is_write, is_read, last_cycle;
    logic [31:0] eff_addr;
    logic        unused_addr_bits;

    // A write wins when both enables are set.
    assign mem_req    = MEM_R_ENIn | MEM_W_ENIn;
    assign is_write   = MEM_W_ENIn;
    assign is_read    = MEM_R_ENIn & ~MEM_W_ENIn;
    assign eff_addr   = ALUResIn - MEM_BASE;
    assign last_cycle = (cnt_q == WAIT_LAST);
    assign unused_addr_bits = ^{eff_addr[31:19], eff_addr[1:0]};

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_d    = state_q;
        cnt_d      = 3'd0;
        data_d     = data_q;
        Freeze     = 1'b0;
        SRAM_ADDR  = 18'd0;
        SRAM_WDATA = 16'd0;
        SRAM_WE_N  = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    Freeze  = 1'b1;
                    state_d = LO;
                end
            end
            LO: begin
                Freeze    = 1'b1;
                SRAM_ADDR = {eff_addr[18:2], 1'b0};
                if (is_write) begin
                    SRAM_WE_N  = 1'b0;
                    SRAM_WDATA = RMValIn[15:0];
                end
                if (last_cycle) begin
                    state_d = HI;
                    if (is_read) data_d[15:0] = SRAM_RDATA;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HI: begin
                Freeze    = 1'b1;
                SRAM_ADDR = {eff_addr[18:2], 1'b1};
                if (is_write) begin
                    SRAM_WE_N  = 1'b0;
                    SRAM_WDATA = RMValIn[31:16];
                end
                if (last_cycle) begin
                    state_d = DONE;
                    if (is_read) data_d[31:16] = SRAM_RDATA;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A pending request must not stall the pipeline while reset is held.
        if (!rst) Freeze = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_ENOut    <= 1'b0;
            MEM_R_ENOut <= 1'b0;
            ALUResOut   <= 32'd0;
            MemDataOut  <= 32'd0;
            DestOut     <= 4'd0;
        end else if (!Freeze) begin
            WB_ENOut    <= WB_ENIn;
            MEM_R_ENOut <= MEM_R_ENIn;
            ALUResOut   <= ALUResIn;
            DestOut     <= DestIn;
            if (state_q == DONE && is_read) MemDataOut <= data_q;
        end else begin
            // Stall: insert a bubble, keep the data fields.
            WB_ENOut    <= 1'b0;
            MEM_R_ENOut <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES=1 and 0), an SRAM array,
// and a reference memory/latency model driven by directed and random operations.
module tb_mem_access_ctrl;

    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, sel;
    logic        wb_en, r_en, w_en;
    logic [31:0] alu_res, rm_val;
    logic [3:0]  dest;
    logic [15:0] sram_rdata;

    logic        a_freeze, a_we_n, a_wb, a_mrd;
    logic [17:0] a_addr;
    logic [15:0] a_wdata;
    logic [31:0] a_alu, a_mdo;
    logic [3:0]  a_dest;
    logic        b_freeze, b_we_n, b_wb, b_mrd;
    logic [17:0] b_addr;
    logic [15:0] b_wdata;
    logic [31:0] b_alu, b_mdo;
    logic [3:0]  b_dest;

    logic        freeze, sram_we_n, wb_o, mrd_o;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [31:0] alu_o, mdo_o;
    logic [3:0]  dest_o;

    mem_access_ctrl #(.WAIT_CYCLES(1), .MEM_BASE(BASE)) dut_a (
        .clk(clk), .rst(rst_a), .WB_ENIn(wb_en), .MEM_R_ENIn(r_en), .MEM_W_ENIn(w_en),
        .ALUResIn(alu_res), .RMValIn(rm_val), .DestIn(dest), .Freeze(a_freeze),
        .SRAM_ADDR(a_addr), .SRAM_WDATA(a_wdata), .SRAM_RDATA(sram_rdata), .SRAM_WE_N(a_we_n),
        .WB_ENOut(a_wb), .MEM_R_ENOut(a_mrd), .ALUResOut(a_alu), .MemDataOut(a_mdo), .DestOut(a_dest)
    );

    mem_access_ctrl #(.WAIT_CYCLES(0), .MEM_BASE(BASE)) dut_b (
        .clk(clk), .rst(rst_b), .WB_ENIn(wb_en), .MEM_R_ENIn(r_en), .MEM_W_ENIn(w_en),
        .ALUResIn(alu_res), .RMValIn(rm_val), .DestIn(dest), .Freeze(b_freeze),
        .SRAM_ADDR(b_addr), .SRAM_WDATA(b_wdata), .SRAM_RDATA(sram_rdata), .SRAM_WE_N(b_we_n),
        .WB_ENOut(b_wb), .MEM_R_ENOut(b_mrd), .ALUResOut(b_alu), .MemDataOut(b_mdo), .DestOut(b_dest)
    );

    assign freeze     = sel ? b_freeze : a_freeze;
    assign sram_we_n  = sel ? b_we_n   : a_we_n;
    assign sram_addr  = sel ? b_addr   : a_addr;
    assign sram_wdata = sel ? b_wdata  : a_wdata;
    assign wb_o       = sel ? b_wb     : a_wb;
    assign mrd_o      = sel ? b_mrd    : a_mrd;
    assign alu_o      = sel ? b_alu    : a_alu;
    assign mdo_o      = sel ? b_mdo    : a_mdo;
    assign dest_o     = sel ? b_dest   : a_dest;

    // Physical SRAM seen by the active instance; ref_mem is the expected contents.
    logic [15:0] sram    [0:63];
    logic [15:0] ref_mem [0:63];
    assign sram_rdata = sram[sram_addr[5:0]];
    always @(posedge clk) if (!sram_we_n) sram[sram_addr[5:0]] <= sram_wdata;

    int          checks = 0;
    int          errors = 0;
    int          cur_wait;
    logic [31:0] exp_mdo;

    task automatic run_op(input string name, input logic r, input logic w, input logic wb,
                          input logic [31:0] addr, input logic [31:0] data, input logic [3:0] d);
        int          exp_fz, exp_we, fz_cnt, we_cnt, bad_bus, bad_bub, cyc;
        bit          done;
        logic [17:0] lo_a, hi_a, ea;
        logic [15:0] ew;
        logic        ewe;
        logic [31:0] exp_ctl, got_ctl;
        lo_a   = 18'(((addr - BASE) >> 2) * 2);
        hi_a   = lo_a + 18'd1;
        exp_fz = (r || w) ? 2 * (cur_wait + 1) + 1 : 0;
        exp_we = w ? 2 * (cur_wait + 1) : 0;
        wb_en = wb; r_en = r; w_en = w; alu_res = addr; rm_val = data; dest = d;
        fz_cnt = 0; we_cnt = 0; bad_bus = 0; bad_bub = 0; cyc = 0; done = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            if (cyc > 0 && (wb_o !== 1'b0 || mrd_o !== 1'b0)) bad_bub++;
            ea = 18'd0; ew = 16'd0; ewe = 1'b1;
            if (!freeze) begin
                done = 1;
            end else begin
                fz_cnt++;
                if (cyc >= 1 && cyc <= cur_wait + 1) begin
                    ea = lo_a; ewe = !w; ew = w ? data[15:0] : 16'd0;
                end else if (cyc > cur_wait + 1) begin
                    ea = hi_a; ewe = !w; ew = w ? data[31:16] : 16'd0;
                end
            end
            if (!sram_we_n) we_cnt++;
            if (sram_addr !== ea || sram_we_n !== ewe || sram_wdata !== ew) bad_bus++;
            if (!done) begin
                @(posedge clk);
                cyc++;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: Freeze still high after %0d cycles, want low after %0d", name, cyc, exp_fz);
        end
        checks++;
        if (fz_cnt !== exp_fz) begin
            errors++;
            $display("FAIL %s freeze_cycles got %0d want %0d", name, fz_cnt, exp_fz);
        end
        checks++;
        if (we_cnt !== exp_we) begin
            errors++;
            $display("FAIL %s we_low_cycles got %0d want %0d", name, we_cnt, exp_we);
        end
        checks++;
        if (bad_bus !== 0) begin
            errors++;
            $display("FAIL %s sram_bus bad_cycles got %0d want 0 (lo=%0d hi=%0d)", name, bad_bus, lo_a, hi_a);
        end
        checks++;
        if (bad_bub !== 0) begin
            errors++;
            $display("FAIL %s stall_bubble bad_cycles got %0d want 0", name, bad_bub);
        end
        @(posedge clk);
        #1;
        if (r && !w) exp_mdo = {ref_mem[hi_a[5:0]], ref_mem[lo_a[5:0]]};
        if (w) begin
            ref_mem[lo_a[5:0]] = data[15:0];
            ref_mem[hi_a[5:0]] = data[31:16];
        end
        exp_ctl = {wb, r, 2'b00, d, 24'd0};
        got_ctl = {wb_o, mrd_o, 2'b00, dest_o, 24'd0};
        checks++;
        if (got_ctl !== exp_ctl || alu_o !== addr) begin
            errors++;
            $display("FAIL %s memwb_ctl got wb=%b r=%b dest=%0d alu=%h want wb=%b r=%b dest=%0d alu=%h",
                     name, wb_o, mrd_o, dest_o, alu_o, wb, r, d, addr);
        end
        checks++;
        if (mdo_o !== exp_mdo) begin
            errors++;
            $display("FAIL %s mem_data got %h want %h", name, mdo_o, exp_mdo);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (freeze !== 1'b0 || sram_we_n !== 1'b1 || sram_addr !== 18'd0 || sram_wdata !== 16'd0 ||
            wb_o !== 1'b0 || mrd_o !== 1'b0 || alu_o !== 32'd0 || mdo_o !== 32'd0 || dest_o !== 4'd0) begin
            errors++;
            $display("FAIL %s reset_outputs got fz=%b we_n=%b addr=%h wd=%h wb=%b r=%b alu=%h mdo=%h dest=%h want all 0, we_n=1",
                     name, freeze, sram_we_n, sram_addr, sram_wdata, wb_o, mrd_o, alu_o, mdo_o, dest_o);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0;
        wb_en = 1'b1; r_en = 1'b1; w_en = 1'b1;
        alu_res = 32'h408; rm_val = 32'hFFFF_FFFF; dest = 4'hF;
        sel = 1'b0;
        #7 check_all_zero("reset_a");
        sel = 1'b1;
        #1 check_all_zero("reset_b");
        sel = 1'b0;
        r_en = 1'b0; w_en = 1'b0;
        exp_mdo = 32'd0; cur_wait = 1;
        @(negedge clk) rst_a = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu();
        run_op("alu", 1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 4'd3);
    endtask

    task automatic test_load();
        sram[4] = 16'hBEEF; ref_mem[4] = 16'hBEEF;
        sram[5] = 16'hDEAD; ref_mem[5] = 16'hDEAD;
        run_op("load_408", 1'b1, 1'b0, 1'b1, 32'h408, 32'h0, 4'd7);
    endtask

    task automatic test_store();
        run_op("store_400", 1'b0, 1'b1, 1'b1, 32'h400, 32'h1234_5678, 4'd2);
        run_op("load_after_store", 1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 4'd4);
    endtask

    task automatic test_both_enables();
        run_op("both_rw", 1'b1, 1'b1, 1'b1, 32'h400, 32'hCAFE_F00D, 4'd5);
        run_op("load_after_both", 1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 4'd6);
    endtask

    task automatic test_reset_mid_access();
        wb_en = 1'b1; r_en = 1'b1; w_en = 1'b0; alu_res = 32'h410; dest = 4'd9;
        repeat (3) @(posedge clk);
        #2 rst_a = 1'b0;
        #1 check_all_zero("reset_mid_hi");
        r_en = 1'b0;
        exp_mdo = 32'd0;
        #2 rst_a = 1'b1;
        @(posedge clk);
        #1;
        run_op("load_after_reset", 1'b1, 1'b0, 1'b1, 32'h410, 32'h0, 4'd9);
    endtask

    task automatic test_random(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            int          kind;
            logic [31:0] addr;
            kind = $urandom_range(0, 3);
            addr = BASE + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
            case (kind)
                0: run_op(name, 1'b0, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
                1: run_op(name, 1'b1, 1'b0, 1'($urandom), addr, $urandom, 4'($urandom));
                2: run_op(name, 1'b0, 1'b1, 1'($urandom), addr, $urandom, 4'($urandom));
                default: run_op(name, 1'b1, 1'b1, 1'($urandom), addr, $urandom, 4'($urandom));
            endcase
        end
    endtask

    task automatic test_back_to_back();
        rst_a = 1'b0;
        r_en = 1'b0; w_en = 1'b0;
        sel = 1'b1; cur_wait = 0; exp_mdo = 32'd0;
        @(negedge clk) rst_b = 1'b1;
        @(posedge clk);
        #1;
        run_op("b2b_load0", 1'b1, 1'b0, 1'b1, 32'h408, 32'h0, 4'd1);
        run_op("b2b_load1", 1'b1, 1'b0, 1'b1, 32'h40C, 32'h0, 4'd2);
        run_op("b2b_store", 1'b0, 1'b1, 1'b0, 32'h40C, 32'hA5A5_5A5A, 4'd3);
        run_op("b2b_load2", 1'b1, 1'b0, 1'b1, 32'h40C, 32'h0, 4'd4);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            sram[i]    = v;
            ref_mem[i] = v;
        end
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_both_enables();
        test_reset_mid_access();
        test_random("rand_w1", 40);
        test_back_to_back();
        test_random("rand_w0", 40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
